// File: rtl/piso_frame_scheduler_if.sv
// Control bundle between the spectrogram frame scheduler and its requester / PISO datapath.
// The master side drives frame requests; the slave side is the scheduler itself.
interface piso_frame_scheduler_if #(
    parameter int SEL_W = 3
);
    logic             enable;
    logic             frame_req;
    logic             ovr_clr;
    logic [SEL_W-1:0] mux_sel;
    logic             sl;
    logic             frame_sync;
    logic             bit_valid;
    logic             frame_done;
    logic             busy;
    logic             overrun;

    modport master (
        output enable, frame_req, ovr_clr,
        input  mux_sel, sl, frame_sync, bit_valid, frame_done, busy, overrun
    );

    modport slave (
        input  enable, frame_req, ovr_clr,
        output mux_sel, sl, frame_sync, bit_valid, frame_done, busy, overrun
    );
endinterface

// File: rtl/piso_frame_scheduler.sv
// Walks every band channel through the 3-bit PISO once per frame request,
// bracketing each frame with sync/done strobes and queueing one pending request.
module piso_frame_scheduler #(
    parameter int N_CHANNELS = 8,
    parameter int SEL_W      = 3,
    parameter int WORD_BITS  = 3
) (
    input logic                  clk,
    input logic                  reset,
    piso_frame_scheduler_if.slave bus
);
    localparam int CNT_W = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, LOAD, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [SEL_W-1:0] ch, ch_next;
    logic             pending, pending_next;
    logic             overrun_q, overrun_next;
    logic             sl_q, sl_next;
    logic             sync_q, sync_next;
    logic             valid_q, valid_next;
    logic             done_q, done_next;
    logic             busy_q, busy_next;
    logic             start, last_bit, last_ch;

    assign start    = ((state == IDLE) || (state == DONE)) && bus.enable &&
                      (bus.frame_req || pending);
    assign last_bit = (cnt == CNT_W'(1));
    assign last_ch  = (ch == SEL_W'(N_CHANNELS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ch        <= '0;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
            sl_q      <= 1'b0;
            sync_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            ch        <= ch_next;
            pending   <= pending_next;
            overrun_q <= overrun_next;
            sl_q      <= sl_next;
            sync_q    <= sync_next;
            valid_q   <= valid_next;
            done_q    <= done_next;
            busy_q    <= busy_next;
        end
    end

    // The channel register doubles as mux_sel, so it only moves on SYNC or a LOAD advance.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ch_next    = ch;
        case (state)
            IDLE:  if (start) state_next = SYNC;
            SYNC:  state_next = LOAD;
            LOAD: begin
                state_next = SHIFT;
                cnt_next   = CNT_W'(WORD_BITS - 1);
            end
            SHIFT: begin
                cnt_next = cnt - 1'b1;
                if (last_bit) begin
                    if (last_ch) begin
                        state_next = DONE;
                    end else begin
                        state_next = LOAD;
                        ch_next    = ch + 1'b1;
                    end
                end
            end
            DONE:    state_next = start ? SYNC : IDLE;
            default: state_next = IDLE;
        endcase
        if (state_next == SYNC) ch_next = '0;
    end

    // Strobes are computed from the next state so the registered outputs line up with it.
    always_comb begin
        sl_next      = (state_next == LOAD);
        sync_next    = (state_next == SYNC);
        done_next    = (state_next == DONE);
        busy_next    = (state_next != IDLE);
        valid_next   = (state == LOAD) || (state == SHIFT);
        pending_next = pending;
        overrun_next = overrun_q;
        if (start) begin
            pending_next = pending && bus.frame_req;
        end else if (bus.frame_req) begin
            if (pending) overrun_next = 1'b1;
            else         pending_next = 1'b1;
        end
        if (bus.ovr_clr && !(bus.frame_req && pending && !start)) overrun_next = 1'b0;
    end

    assign bus.mux_sel    = ch;
    assign bus.sl         = sl_q;
    assign bus.frame_sync = sync_q;
    assign bus.bit_valid  = valid_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_piso_frame_scheduler.sv
// Directed bench: default 8-channel scheduler driving a behavioural MUX + PISO,
// plus 2- and 16-channel instances sharing the same request stream.
module tb_piso_frame_scheduler;
    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic frame_req;
    logic ovr_clr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int req_cyc     = 0;

    always #5 clk = ~clk;

    piso_frame_scheduler_if #(.SEL_W(3)) if_main ();
    piso_frame_scheduler_if #(.SEL_W(1)) if_n2 ();
    piso_frame_scheduler_if #(.SEL_W(4)) if_n16 ();

    assign if_main.enable    = enable;
    assign if_main.frame_req = frame_req;
    assign if_main.ovr_clr   = ovr_clr;
    assign if_n2.enable      = enable;
    assign if_n2.frame_req   = frame_req;
    assign if_n2.ovr_clr     = ovr_clr;
    assign if_n16.enable     = enable;
    assign if_n16.frame_req  = frame_req;
    assign if_n16.ovr_clr    = ovr_clr;

    piso_frame_scheduler #(.N_CHANNELS(8), .SEL_W(3), .WORD_BITS(3))
        u_main (.clk(clk), .reset(reset), .bus(if_main.slave));
    piso_frame_scheduler #(.N_CHANNELS(2), .SEL_W(1), .WORD_BITS(3))
        u_n2 (.clk(clk), .reset(reset), .bus(if_n2.slave));
    piso_frame_scheduler #(.N_CHANNELS(16), .SEL_W(4), .WORD_BITS(3))
        u_n16 (.clk(clk), .reset(reset), .bus(if_n16.slave));

    // Channel c presents the value c mod 8 to a 3-bit LSB-first PISO.
    logic [2:0] mux_word;
    logic [2:0] piso = 3'b000;
    assign mux_word = 3'(32'(if_main.mux_sel) % 8);
    always @(posedge clk) begin
        if (if_main.sl) piso <= mux_word;
        else            piso <= {1'b0, piso[2:1]};
    end

    int          sync_cyc = 0, done_cyc = 0, frame_count = 0;
    int          bit_count = 0, frame_bit_count = 0;
    logic [63:0] bit_buf = '0, frame_bits = '0;
    int          sync2 = 0, len2 = 0, walk_idx2 = 0, walk_err2 = 0;
    int          sync16 = 0, len16 = 0, walk_idx16 = 0, walk_err16 = 0;
    logic        walk_ok2 = 1'b0, walk_ok16 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (if_main.frame_sync) begin
            sync_cyc  = cyc;
            bit_count = 0;
            bit_buf   = '0;
        end
        if (if_main.bit_valid) begin
            if (bit_count < 64) bit_buf[bit_count] = piso[0];
            bit_count++;
        end
        if (if_main.frame_done) begin
            done_cyc        = cyc;
            frame_bits      = bit_buf;
            frame_bit_count = bit_count;
            frame_count++;
        end
        if (if_n2.frame_sync) begin
            sync2 = cyc; walk_idx2 = 0; walk_err2 = 0;
        end
        if (if_n2.sl) begin
            if (int'(if_n2.mux_sel) != walk_idx2) walk_err2++;
            walk_idx2++;
        end
        if (if_n2.frame_done) begin
            len2     = cyc - sync2 + 1;
            walk_ok2 = (walk_err2 == 0) && (walk_idx2 == 2);
        end
        if (if_n16.frame_sync) begin
            sync16 = cyc; walk_idx16 = 0; walk_err16 = 0;
        end
        if (if_n16.sl) begin
            if (int'(if_n16.mux_sel) != walk_idx16) walk_err16++;
            walk_idx16++;
        end
        if (if_n16.frame_done) begin
            len16     = cyc - sync16 + 1;
            walk_ok16 = (walk_err16 == 0) && (walk_idx16 == 16);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulse_req();
        req_cyc   = cyc;
        frame_req = 1'b1;
        tick(1);
        frame_req = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_count < target && n < budget) begin
            tick(1);
            n++;
        end
        check_output("frame_wait", 64'(frame_count >= target), 64'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [23:0] exp_bits;

    initial begin
        exp_bits  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        reset     = 1'b1;
        enable    = 1'b0;
        frame_req = 1'b0;
        ovr_clr   = 1'b0;
        tick(2);
        check_output("reset_outputs",
                     {if_main.mux_sel, if_main.sl, if_main.frame_sync, if_main.bit_valid,
                      if_main.frame_done, if_main.busy, if_main.overrun}, '0);
        reset = 1'b0;
        enable = 1'b1;
        tick(1);

        $display("[TB] single frame");
        pulse_req();
        check_output("sync_strobe", if_main.frame_sync, 1'b1);
        check_output("sync_latency", 64'(sync_cyc - req_cyc), 64'd1);
        check_output("sync_busy", if_main.busy, 1'b1);
        tick(1);
        check_output("load_ch0", {if_main.sl, if_main.mux_sel}, {1'b1, 3'd0});
        tick(1);
        check_output("shift_valid", {if_main.sl, if_main.bit_valid}, 2'b01);
        wait_frames(1, 40);
        check_output("frame_len", 64'(done_cyc - sync_cyc), 64'd25);
        check_output("bit_count", 64'(frame_bit_count), 64'd24);
        check_output("frame_bits", frame_bits, 64'(exp_bits));
        tick(1);
        check_output("idle_after", {if_main.busy, if_main.bit_valid}, 2'b00);
        check_output("mux_hold", if_main.mux_sel, 3'd7);

        $display("[TB] back-to-back");
        pulse_req();
        tick(9);
        pulse_req();
        check_output("b2b_pending", u_main.pending, 1'b1);
        wait_frames(2, 40);
        tick(1);
        check_output("b2b_sync", if_main.frame_sync, 1'b1);
        check_output("b2b_pending_clr", u_main.pending, 1'b0);
        wait_frames(3, 40);
        check_output("b2b_bits", frame_bits, 64'(exp_bits));
        check_output("b2b_overrun", if_main.overrun, 1'b0);
        tick(1);
        check_output("b2b_idle", if_main.busy, 1'b0);

        $display("[TB] overrun");
        pulse_req();
        tick(3);
        pulse_req();
        tick(3);
        pulse_req();
        check_output("ovr_set", if_main.overrun, 1'b1);
        wait_frames(5, 80);
        tick(5);
        check_output("ovr_two_frames", 64'(frame_count), 64'd5);
        check_output("ovr_idle", if_main.busy, 1'b0);
        check_output("ovr_sticky", if_main.overrun, 1'b1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check_output("ovr_clear", if_main.overrun, 1'b0);
        pulse_req();
        tick(2);
        pulse_req();
        tick(2);
        frame_req = 1'b1;
        ovr_clr   = 1'b1;
        tick(1);
        frame_req = 1'b0;
        ovr_clr   = 1'b0;
        check_output("ovr_set_wins", if_main.overrun, 1'b1);
        wait_frames(7, 80);
        tick(2);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check_output("ovr_clear2", if_main.overrun, 1'b0);

        $display("[TB] enable gating");
        enable = 1'b0;
        pulse_req();
        tick(2);
        check_output("gate_busy", if_main.busy, 1'b0);
        check_output("gate_pending", u_main.pending, 1'b1);
        enable = 1'b1;
        tick(1);
        check_output("gate_sync", if_main.frame_sync, 1'b1);
        tick(5);
        enable = 1'b0;
        wait_frames(8, 40);
        check_output("gate_bits", frame_bits, 64'(exp_bits));
        tick(1);
        check_output("gate_stop", if_main.busy, 1'b0);
        pulse_req();
        tick(3);
        check_output("gate_wait", {if_main.busy, u_main.pending}, 2'b01);
        enable = 1'b1;
        tick(1);
        check_output("gate_resume", if_main.frame_sync, 1'b1);
        wait_frames(9, 40);
        tick(1);

        $display("[TB] reset mid-frame");
        pulse_req();
        tick(2);
        pulse_req();
        tick(8);
        check_output("pre_reset_shift", {if_main.sl, if_main.mux_sel}, {1'b0, 3'd3});
        reset = 1'b1;
        #1;
        check_output("async_reset",
                     {if_main.mux_sel, if_main.sl, if_main.busy, if_main.bit_valid},
                     '0);
        check_output("reset_pending", u_main.pending, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(3);
        check_output("post_reset_idle", if_main.busy, 1'b0);
        pulse_req();
        check_output("post_reset_sync", 64'(sync_cyc - req_cyc), 64'd1);
        wait_frames(10, 40);
        check_output("post_reset_len", 64'(done_cyc - sync_cyc + 1), 64'd26);
        check_output("post_reset_bits", frame_bits, 64'(exp_bits));

        $display("[TB] parameter sweep");
        tick(30);
        check_output("n2_len", 64'(len2), 64'd8);
        check_output("n2_walk", walk_ok2, 1'b1);
        check_output("n16_len", 64'(len16), 64'd50);
        check_output("n16_walk", walk_ok16, 1'b1);
        check_output("n16_idle", {if_n16.busy, if_n16.mux_sel}, {1'b0, 4'd15});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
